// File: rtl/gray_step_if.sv
// Bundles the sample inputs and decoded outputs of the gray step counter.
// Master drives the Gray sample stream; slave is the counter itself.
interface gray_step_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [1:0]       gray_in;
  logic             err_clr;
  logic [WIDTH-1:0] position;
  logic [1:0]       bin_out;
  logic             step;
  logic             dir;
  logic             error;

  modport master (
    output enable, gray_in, err_clr,
    input  position, bin_out, step, dir, error
  );

  modport slave (
    input  enable, gray_in, err_clr,
    output position, bin_out, step, dir, error
  );
endinterface

// File: rtl/gray_step_counter.sv
// Decodes a 2-bit Gray stream into up/down steps, accumulates a position count,
// reports last direction and flags illegal two-bit jumps (sticky).
module gray_step_counter #(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_clear,
  gray_step_if.slave  io_bus
);

  // state | meaning
  // INIT  | no valid previous sample yet; next enabled edge only captures it
  // TRACK | previous sample valid; each enabled edge is decoded as a transition
  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_TRACK = 1'b1;

  localparam logic [WIDTH-1:0] POS_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] POS_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]       r_state;
  logic [1:0]       r_prev;
  logic [WIDTH-1:0] r_position;
  logic [1:0]       r_bin;
  logic             r_step;
  logic             r_dir;
  logic             r_error;

  logic             w_fwd;
  logic             w_rev;
  logic             w_illegal;
  logic [WIDTH-1:0] w_pos_up;
  logic [WIDTH-1:0] w_pos_dn;
  logic [1:0]       w_bin;

  function automatic logic [1:0] f_gray_next(input logic [1:0] g);
    logic [1:0] n;
    case (g)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  assign w_fwd     = (io_bus.gray_in == f_gray_next(r_prev));
  assign w_rev     = (r_prev == f_gray_next(io_bus.gray_in));
  assign w_illegal = ((io_bus.gray_in ^ r_prev) == 2'b11);
  assign w_bin     = {io_bus.gray_in[1], io_bus.gray_in[1] ^ io_bus.gray_in[0]};

  // Saturating mode pins the count at the rails; step/dir still report motion.
  generate
    if (WRAP) begin : g_wrap
      assign w_pos_up = r_position + POS_ONE;
      assign w_pos_dn = r_position - POS_ONE;
    end else begin : g_sat
      assign w_pos_up = (r_position == POS_MAX) ? r_position : r_position + POS_ONE;
      assign w_pos_dn = (r_position == '0)      ? r_position : r_position - POS_ONE;
    end
  endgenerate

  always_ff @(posedge i_clock) begin
    if (!i_clear) begin
      r_state    <= S_INIT;
      r_prev     <= 2'b00;
      r_position <= '0;
      r_bin      <= 2'b00;
      r_step     <= 1'b0;
      r_dir      <= 1'b1;
      r_error    <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (io_bus.err_clr) begin
        r_error <= 1'b0;
      end
      if (io_bus.enable) begin
        r_bin  <= w_bin;
        r_prev <= io_bus.gray_in;
        if (r_state == S_INIT) begin
          r_state <= S_TRACK;
        end else if (w_fwd) begin
          r_position <= w_pos_up;
          r_dir      <= 1'b1;
          r_step     <= 1'b1;
        end else if (w_rev) begin
          r_position <= w_pos_dn;
          r_dir      <= 1'b0;
          r_step     <= 1'b1;
        end else if (w_illegal) begin
          // Later assignment lets a detected jump win over err_clr.
          r_error <= 1'b1;
        end
      end
    end
  end

  assign io_bus.position = r_position;
  assign io_bus.bin_out  = r_bin;
  assign io_bus.step     = r_step;
  assign io_bus.dir      = r_dir;
  assign io_bus.error    = r_error;

endmodule

// File: tb/tb_gray_step_counter.sv
// Bench for gray_step_counter: a wrapping 8-bit and a saturating 3-bit instance
// fed the same stream, compared every cycle against a positional reference model.
module tb_gray_step_counter;

  logic i_clock = 1'b0;
  logic i_clear;

  gray_step_if #(.WIDTH(8)) bus_a ();
  gray_step_if #(.WIDTH(3)) bus_b ();

  gray_step_counter #(.WIDTH(8), .WRAP(1'b1)) u_dut_a (
    .i_clock (i_clock),
    .i_clear (i_clear),
    .io_bus  (bus_a.slave)
  );

  gray_step_counter #(.WIDTH(3), .WRAP(1'b0)) u_dut_b (
    .i_clock (i_clock),
    .i_clear (i_clear),
    .io_bus  (bus_b.slave)
  );

  always #5 i_clock = ~i_clock;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  bit         m_init;
  logic [1:0] m_prev;
  int         m_pos_a;
  int         m_pos_b;
  bit         m_step;
  bit         m_dir;
  bit         m_err;
  int         m_bin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // position of a Gray code in the forward cycle 00,01,11,10
  function automatic int idx_of(input logic [1:0] g);
    case (g)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray_of(input int i);
    case (i & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_edge(input bit en, input logic [1:0] g, input bit ec, input bit clr);
    int d;
    if (!clr) begin
      m_init = 1; m_prev = 2'b00; m_pos_a = 0; m_pos_b = 0;
      m_step = 0; m_dir = 1; m_err = 0; m_bin = 0;
      return;
    end
    m_step = 0;
    if (ec) m_err = 0;
    if (en) begin
      m_bin = idx_of(g);
      if (m_init) begin
        m_init = 0;
      end else begin
        d = (idx_of(g) - idx_of(m_prev) + 4) % 4;
        if (d == 1) begin
          m_pos_a = (m_pos_a + 1) % 256;
          m_pos_b = (m_pos_b < 7) ? m_pos_b + 1 : 7;
          m_dir = 1; m_step = 1;
        end else if (d == 3) begin
          m_pos_a = (m_pos_a + 255) % 256;
          m_pos_b = (m_pos_b > 0) ? m_pos_b - 1 : 0;
          m_dir = 0; m_step = 1;
        end else if (d == 2) begin
          m_err = 1;
        end
      end
      m_prev = g;
    end
  endtask

  task automatic cyc(input bit en, input logic [1:0] g, input bit ec, input bit clr);
    i_clear = clr;
    bus_a.enable = en; bus_a.gray_in = g; bus_a.err_clr = ec;
    bus_b.enable = en; bus_b.gray_in = g; bus_b.err_clr = ec;
    @(posedge i_clock);
    model_edge(en, g, ec, clr);
    #1;
    chk("pos_wrap",  32'(bus_a.position), 32'(m_pos_a));
    chk("pos_sat",   32'(bus_b.position), 32'(m_pos_b));
    chk("bin_out",   32'(bus_a.bin_out),  32'(m_bin));
    chk("step",      32'(bus_a.step),     32'(m_step));
    chk("dir",       32'(bus_a.dir),      32'(m_dir));
    chk("error",     32'(bus_a.error),    32'(m_err));
    chk("step_sat",  32'(bus_b.step),     32'(m_step));
    chk("dir_sat",   32'(bus_b.dir),      32'(m_dir));
    chk("error_sat", 32'(bus_b.error),    32'(m_err));
  endtask

  initial begin
    int k;
    i_clear = 1'b0;
    bus_a.enable = 0; bus_a.gray_in = 2'b00; bus_a.err_clr = 0;
    bus_b.enable = 0; bus_b.gray_in = 2'b00; bus_b.err_clr = 0;
    m_init = 1; m_prev = 0; m_pos_a = 0; m_pos_b = 0;
    m_step = 0; m_dir = 1; m_err = 0; m_bin = 0;

    // reset with other inputs active, then idle at 00
    cyc(1, 2'b11, 1, 0);
    cyc(1, 2'b00, 0, 0);
    chk("rst_dir", 32'(bus_a.dir), 32'd1);
    cyc(1, 2'b00, 0, 1);
    cyc(1, 2'b00, 0, 1);
    chk("idle_step", 32'(bus_a.step), 32'd0);

    // forward full cycle
    cyc(1, 2'b00, 0, 0);
    cyc(1, 2'b00, 0, 1);
    cyc(1, 2'b01, 0, 1);
    cyc(1, 2'b11, 0, 1);
    cyc(1, 2'b10, 0, 1);
    chk("fwd_bin3", 32'(bus_a.bin_out), 32'd3);
    cyc(1, 2'b00, 0, 1);
    chk("fwd_pos4", 32'(bus_a.position), 32'd4);
    chk("fwd_dir", 32'(bus_a.dir), 32'd1);

    // reverse two steps
    cyc(1, 2'b00, 0, 1);
    cyc(1, 2'b10, 0, 1);
    cyc(1, 2'b11, 0, 1);
    chk("rev_pos2", 32'(bus_a.position), 32'd2);
    chk("rev_dir", 32'(bus_a.dir), 32'd0);

    // underflow wrap vs saturate, then back up
    cyc(1, 2'b00, 0, 0);
    cyc(1, 2'b00, 0, 1);
    cyc(1, 2'b10, 0, 1);
    chk("wrap_255", 32'(bus_a.position), 32'd255);
    chk("sat_0", 32'(bus_b.position), 32'd0);
    chk("sat_step", 32'(bus_b.step), 32'd1);
    cyc(1, 2'b00, 0, 1);
    chk("wrap_0", 32'(bus_a.position), 32'd0);

    // illegal jump, set-wins with err_clr, clear on legal step
    cyc(1, 2'b00, 0, 0);
    cyc(1, 2'b00, 0, 1);
    cyc(1, 2'b01, 0, 1);
    cyc(1, 2'b10, 0, 1);
    chk("ill_err", 32'(bus_a.error), 32'd1);
    chk("ill_pos", 32'(bus_a.position), 32'd1);
    cyc(1, 2'b01, 1, 1);
    chk("ill_setwins", 32'(bus_a.error), 32'd1);
    cyc(1, 2'b11, 1, 1);
    chk("ill_cleared", 32'(bus_a.error), 32'd0);

    // enable low freezes, re-enable with a two-bit jump
    cyc(1, 2'b00, 0, 0);
    cyc(1, 2'b00, 0, 1);
    cyc(0, 2'b00, 0, 1);
    cyc(0, 2'b01, 0, 1);
    cyc(0, 2'b11, 0, 1);
    chk("frz_bin", 32'(bus_a.bin_out), 32'd0);
    cyc(1, 2'b11, 0, 1);
    chk("reen_err", 32'(bus_a.error), 32'd1);

    // err_clr while disabled
    cyc(0, 2'b11, 1, 1);
    chk("clr_dis", 32'(bus_a.error), 32'd0);

    // mid-count reset at position 7
    cyc(1, 2'b00, 0, 0);
    cyc(1, 2'b00, 0, 1);
    for (int i = 1; i <= 7; i++) cyc(1, gray_of(i), 0, 1);
    chk("pos7", 32'(bus_a.position), 32'd7);
    cyc(1, gray_of(0), 0, 0);
    chk("mid_rst_pos", 32'(bus_a.position), 32'd0);
    chk("mid_rst_dir", 32'(bus_a.dir), 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 99);
      if (k < 40)      k = 1;
      else if (k < 80) k = 3;
      else if (k < 90) k = 0;
      else             k = 2;
      cyc(($urandom_range(0, 9) < 8),
          gray_of(idx_of(m_prev) + k),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 99) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_step_counter.md
Name: gray_step_counter

Overview:
- Downstream consumer of the 2-bit Gray-code counter stage.
- Samples the 2-bit Gray value every enabled cycle and decodes each legal transition into an up or down step.
- Accumulates a signed-agnostic position count, reports direction, and flags illegal two-bit jumps.
- Feeds display/readout logic with a binary position and a per-step strobe.

Parameters:
WIDTH, 8, position counter width in bits (2..16)
WRAP, 1, 1 = position wraps modulo 2^WIDTH; 0 = position saturates at 0 and 2^WIDTH-1

Ports:
clock  input  1  system clock, all state updates on rising edge
clear  input  1  synchronous reset, active-low
enable  input  1  sample qualifier; 0 = hold all state
gray_in  input  2  Gray code from upstream counter
err_clr  input  1  synchronous clear of sticky error flag
position  output  WIDTH  accumulated step count
bin_out  output  2  registered binary decode of last sampled gray_in
step  output  1  one-cycle pulse on each legal step
dir  output  1  direction of last legal step (1 = up, 0 = down)
error  output  1  sticky illegal-transition flag

Behaviour:
- Reset:
  - clear = 0 at a rising edge forces position = 0, bin_out = 0, step = 0, dir = 1, error = 0, prev = 2'b00, state = INIT.
  - Reset overrides all other inputs and may occur mid-operation.
- Forward Gray sequence: 00 -> 01 -> 11 -> 10 -> 00. The reverse order is down.
- bin_out = {g[1], g[1]^g[0]} of gray_in, registered on every enabled edge (00->0, 01->1, 11->2, 10->3).
- FSM with two states, INIT and TRACK:
  - INIT:
    - On the first enabled edge: prev <= gray_in, bin_out updated, no step, no error check.
    - Transition to TRACK.
  - TRACK, on each enabled edge, compare gray_in against prev:
    - Equal: no step, step = 0, position unchanged.
    - Forward neighbour: position <= position + 1, dir <= 1, step <= 1.
    - Reverse neighbour: position <= position - 1, dir <= 0, step <= 1.
    - Both bits differ (gray_in ^ prev = 11): error <= 1, no count, step = 0, dir unchanged.
    - prev <= gray_in in every case above.
- enable = 0:
  - prev, position, dir, error and bin_out hold.
  - step = 0.
  - State unchanged; INIT stays INIT.
- Latency: the gray_in value sampled at edge k is reflected in position, step, dir and bin_out immediately after edge k (one register stage).
- step is high for exactly one cycle per legal transition. It is never high on two consecutive cycles unless gray_in changes on consecutive enabled edges.
- Wrap/saturate:
  - WRAP = 1: 2^WIDTH-1 + 1 -> 0 and 0 - 1 -> 2^WIDTH-1.
  - WRAP = 0: position holds at the limit; step and dir still update.
- error:
  - Sticky; cleared only by err_clr = 1 or reset.
  - err_clr acts regardless of enable.
  - If err_clr = 1 and an illegal transition occur on the same edge, error = 1 (set wins).

Test Plan:
- Reset then 2 cycles enabled with gray_in = 00 -> position = 0, step never 1, error = 0, bin_out = 0, state TRACK after first edge.
- From reset, drive 00,01,11,10,00 on consecutive enabled edges -> step pulses 4 times, dir = 1, position = 4, bin_out sequence 0,1,2,3,0.
- From position 4, drive 00,10,11 -> position = 2, dir = 0, two step pulses.
- WIDTH = 8, WRAP = 1: 0 down one step -> position = 255; then up one step -> position = 0. With WRAP = 0: 0 down -> position stays 0, step = 1, dir = 0.
- Illegal transitions: prev = 01, gray_in = 10 -> error = 1, position unchanged, step = 0. Next, err_clr = 1 together with 10 -> 01 -> error stays 1. Then err_clr = 1 with a legal step -> error = 0.
- Enable and mid-operation reset:
  - enable = 0 while gray_in steps 00 -> 01 -> 11 -> outputs frozen, step = 0.
  - Re-enable with gray_in = 11 (prev = 00) -> error = 1.
  - Assert clear = 0 mid-count at position = 7 -> all outputs return to reset values on that edge.
